// File: rtl/epoca.sv
// epoca: one training epoch of a two-input FP16 perceptron with bias.
// Rev 1.0 -- LOAD, four SAMPLE cycles, then DONE; truncating FP16 mul/add.
`default_nettype none

module epoca #(
  parameter int WIDTH     = 16,
  parameter int N_SAMPLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_SAMPLES*WIDTH-1:0]   in1,
  input  logic [N_SAMPLES*WIDTH-1:0]   in2,
  input  logic [N_SAMPLES*WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]             u,
  input  logic [WIDTH-1:0]             w0,
  input  logic [WIDTH-1:0]             w1,
  input  logic [WIDTH-1:0]             w2,
  output logic [N_SAMPLES*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]             w0_out,
  output logic [WIDTH-1:0]             w1_out,
  output logic [WIDTH-1:0]             w2_out,
  output logic                         done
);

  typedef enum logic [1:0] {LOAD = 2'd0, SAMPLE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] ONE     = 16'h3C00;
  localparam logic [14:0] MAX_MAG = 15'h7BFF;

  // Truncating FP16 multiply; subnormals flush to signed zero, overflow saturates.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic               s;
    logic [21:0]        prod;
    logic signed [6:0]  er;
    logic [9:0]         frac;
    s    = a[15] ^ b[15];
    prod = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    er   = $signed({2'b00, a[14:10]}) + $signed({2'b00, b[14:10]}) - 7'sd15;
    if (prod[21]) begin
      frac = 10'(prod >> 11);
      er   = er + 7'sd1;
    end else begin
      frac = 10'(prod >> 10);
    end
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) fmul = {s, 15'd0};
    else if (er >= 7'sd31)                    fmul = {s, MAX_MAG};
    else if (er <= 7'sd0)                     fmul = {s, 15'd0};
    else                                      fmul = {s, er[4:0], frac};
  endfunction

  // Truncating FP16 add with guard/round/sticky alignment; adding a zero returns the other operand.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic               az, bz;
    logic [15:0]        big, sml;
    logic [4:0]         dexp;
    logic [13:0]        mb, ms;
    logic [27:0]        sh;
    logic [14:0]        sum;
    logic [13:0]        norm;
    logic [3:0]         lz;
    logic signed [6:0]  er;
    az = (a[14:10] == 5'd0);
    bz = (b[14:10] == 5'd0);
    if (a[14:0] >= b[14:0]) begin big = a; sml = b; end
    else                    begin big = b; sml = a; end
    dexp = big[14:10] - sml[14:10];
    mb   = {1'b1, big[9:0], 3'b000};
    ms   = {1'b1, sml[9:0], 3'b000};
    sh   = {ms, 14'd0} >> dexp;
    if (dexp > 5'd27) ms = 14'd1;
    else              ms = sh[27:14] | {13'd0, |sh[13:0]};
    if (big[15] ^ sml[15]) sum = {1'b0, mb} - {1'b0, ms};
    else                   sum = {1'b0, mb} + {1'b0, ms};
    lz = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (sum[i]) lz = 4'(13 - i);
    end
    if (sum[14]) begin
      norm = sum[14:1] | {13'd0, sum[0]};
      er   = $signed({2'b00, big[14:10]}) + 7'sd1;
    end else begin
      norm = sum[13:0] << lz;
      er   = $signed({2'b00, big[14:10]}) - $signed({3'b000, lz});
    end
    if (bz)                  fadd = {a[15], az ? 15'd0 : a[14:0]};
    else if (az)             fadd = b;
    else if (sum == 15'd0)   fadd = 16'h0000;
    else if (er >= 7'sd31)   fadd = {big[15], MAX_MAG};
    else if (er <= 7'sd0)    fadd = {big[15], 15'd0};
    else                     fadd = {big[15], er[4:0], 10'(norm >> 3)};
  endfunction

  state_t                       state, state_nxt;
  logic [1:0]                   idx, idx_nxt;
  logic [N_SAMPLES*WIDTH-1:0]   result_nxt;
  logic [WIDTH-1:0]             w0_nxt, w1_nxt, w2_nxt;
  logic [WIDTH-1:0]             x1, x2, dk, net, y, e, ue;

  assign x1  = in1[idx*WIDTH +: WIDTH];
  assign x2  = in2[idx*WIDTH +: WIDTH];
  assign dk  = d[idx*WIDTH +: WIDTH];
  assign net = fadd(fadd(w0_out, fmul(w1_out, x1)), fmul(w2_out, x2));
  assign y   = (!net[15] && net[14:0] != 15'd0) ? ONE : 16'h0000;
  assign e   = fadd(dk, y ^ 16'h8000);
  assign ue  = fmul(u, e);
  assign done = (state == DONE);

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    result_nxt = result;
    w0_nxt     = w0_out;
    w1_nxt     = w1_out;
    w2_nxt     = w2_out;
    case (state)
      LOAD: begin
        w0_nxt    = w0;
        w1_nxt    = w1;
        w2_nxt    = w2;
        idx_nxt   = 2'd0;
        state_nxt = SAMPLE;
      end
      SAMPLE: begin
        result_nxt[idx*WIDTH +: WIDTH] = y;
        w0_nxt  = fadd(w0_out, ue);
        w1_nxt  = fadd(w1_out, fmul(ue, x1));
        w2_nxt  = fadd(w2_out, fmul(ue, x2));
        idx_nxt = idx + 2'd1;
        if (idx == 2'(N_SAMPLES - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= LOAD;
      idx    <= 2'd0;
      result <= '0;
      w0_out <= '0;
      w1_out <= '0;
      w2_out <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      result <= result_nxt;
      w0_out <= w0_nxt;
      w1_out <= w1_nxt;
      w2_out <= w2_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_epoca.sv
// tb_epoca: table-driven epoch vectors plus reset-abort and DONE-hold sequences for epoca.
`default_nettype none

module tb_epoca;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in1, in2, d, result;
  logic [15:0] u, w0, w1, w2, w0_out, w1_out, w2_out;
  logic        done;
  int          total = 0;
  int          passed = 0;

  typedef struct {
    logic [63:0] in1, in2, d;
    logic [15:0] u, w0, w1, w2;
    logic [63:0] res;
    logic [15:0] ew0, ew1, ew2;
  } vec_t;

  vec_t vecs[6];

  epoca #(.WIDTH(16), .N_SAMPLES(4)) dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .d(d), .u(u),
    .w0(w0), .w1(w1), .w2(w2), .result(result),
    .w0_out(w0_out), .w1_out(w1_out), .w2_out(w2_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic load_vec(input vec_t v);
    in1 = v.in1; in2 = v.in2; d = v.d; u = v.u; w0 = v.w0; w1 = v.w1; w2 = v.w2;
  endtask

  task automatic start_epoch();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [63:0] OR_IN1 = {16'h3C00, 16'h0000, 16'h3C00, 16'h0000};
  localparam logic [63:0] OR_IN2 = {16'h3C00, 16'h3C00, 16'h0000, 16'h0000};
  localparam logic [63:0] ALL1   = {4{16'h3C00}};

  initial begin
    // sample 0 sits in the low 16 bits of every packed field
    vecs[0] = '{OR_IN1, OR_IN2, {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000},
                16'h3800, 16'h3C00, 16'h3C00, 16'h3C00, ALL1, 16'h3800, 16'h3C00, 16'h3C00};
    vecs[1] = '{OR_IN1, OR_IN2, {16'h3C00, 16'h0000, 16'h0000, 16'h0000},
                16'h3800, 16'h3C00, 16'h3C00, 16'h3C00, ALL1, 16'hB800, 16'h3800, 16'h3800};
    vecs[2] = '{OR_IN1, OR_IN2, {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000},
                16'h3800, 16'h0000, 16'h0000, 16'h0000,
                {16'h3C00, 16'h3C00, 16'h0000, 16'h0000}, 16'h3800, 16'h3800, 16'h0000};
    vecs[3] = '{OR_IN1, OR_IN2, 64'd0,
                16'h3800, 16'h8000, 16'h0000, 16'h0000, 64'd0, 16'h8000, 16'h0000, 16'h0000};
    // 65504*2 saturates the product to 0x7BFF
    vecs[4] = '{{16'h0000, 16'h0000, 16'h0000, 16'h4000}, 64'd0, ALL1,
                16'h3C00, 16'h0000, 16'h7BFF, 16'h0000,
                {16'h3C00, 16'h3C00, 16'h0000, 16'h3C00}, 16'h3C00, 16'h7BFF, 16'h0000};
    // -1 + 1.25*2^-11 truncates to 0xBBFE (nearest-rounding would give 0xBBFF)
    vecs[5] = '{64'd0, 64'd0, {16'h0000, 16'h0000, 16'h0000, 16'h3C00},
                16'h1100, 16'hBC00, 16'h0000, 16'h0000, 64'd0, 16'hBBFE, 16'h0000, 16'h0000};

    reset = 1'b1;
    load_vec(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result, 64'd0);
    check("reset w0", 64'(w0_out), 64'd0);
    check("reset w1", 64'(w1_out), 64'd0);
    check("reset w2", 64'(w2_out), 64'd0);
    check("reset done", 64'(done), 64'd0);

    for (int i = 0; i < 6; i++) begin
      load_vec(vecs[i]);
      start_epoch();
      repeat (4) @(posedge clk);
      #1 check($sformatf("v%0d done@4", i), 64'(done), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d done@5", i), 64'(done), 64'd1);
      check($sformatf("v%0d result", i), result, vecs[i].res);
      check($sformatf("v%0d w0", i), 64'(w0_out), 64'(vecs[i].ew0));
      check($sformatf("v%0d w1", i), 64'(w1_out), 64'(vecs[i].ew1));
      check($sformatf("v%0d w2", i), 64'(w2_out), 64'(vecs[i].ew2));
    end

    // reset asserted between edges mid-epoch clears everything at once
    load_vec(vecs[0]);
    start_epoch();
    repeat (3) @(posedge clk);
    #1;
    check("mid result", result, {32'd0, 16'h3C00, 16'h3C00});
    check("mid w0", 64'(w0_out), 64'h3800);
    reset = 1'b1;
    #1;
    check("abort result", result, 64'd0);
    check("abort w0", 64'(w0_out), 64'd0);
    check("abort w1", 64'(w1_out), 64'd0);
    check("abort w2", 64'(w2_out), 64'd0);
    check("abort done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rerun result", result, vecs[0].res);
    check("rerun w0", 64'(w0_out), 64'h3800);
    check("rerun done", 64'(done), 64'd1);

    // DONE ignores every input change
    in1 = 64'h4000_4000_4000_4000; in2 = 64'hC000_C000_C000_C000; d = 64'd0;
    u = 16'h3C00; w0 = 16'h4400; w1 = 16'hC400; w2 = 16'h1234;
    repeat (10) @(posedge clk);
    #1;
    check("hold result", result, vecs[0].res);
    check("hold w0", 64'(w0_out), 64'h3800);
    check("hold w1", 64'(w1_out), 64'h3C00);
    check("hold w2", 64'(w2_out), 64'h3C00);
    check("hold done", 64'(done), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/epoca.md
Name: epoca

Overview:
- One training epoch of a two-input perceptron with a bias weight, using IEEE-754 half-precision (FP16) arithmetic.
- Loads initial weights, then presents four training samples, one per clock cycle.
- For each sample it records the perceptron output and applies the perceptron learning rule.
- Exposes the four per-sample outputs and the final weights. It is the training engine used by the neuron test harnesses.

Parameters:
- WIDTH, 16, word width; FP16 only (1 sign, 5 exponent bits with bias 15, 10 mantissa bits); other values are unsupported.
- N_SAMPLES, 4, samples per epoch; fixed at 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in1  in  4x16 packed  input x1 per sample; sample k in bits [16k+15:16k]
- in2  in  4x16 packed  input x2 per sample; same packing
- d  in  4x16 packed  desired output per sample; must be 0.0 (0x0000) or 1.0 (0x3C00)
- u  in  16  learning rate (FP16)
- w0  in  16  initial bias weight
- w1  in  16  initial weight for x1
- w2  in  16  initial weight for x2
- result  out  4x16 packed  perceptron output per sample; each 0x0000 or 0x3C00
- w0_out  out  16  current/final bias weight
- w1_out  out  16  current/final w1
- w2_out  out  16  current/final w2
- done  out  1  high once all four samples are processed

Behaviour:
- Reset (asynchronous, active-high):
  - State = LOAD, sample index = 0.
  - result, w0_out, w1_out, w2_out all 0x0000; done = 0.
  - Reset asserted at any time, including mid-epoch, aborts the epoch immediately.
- LOAD: on the first rising edge after reset release, the weight registers take w0/w1/w2; the state moves to SAMPLE with idx = 0.
- SAMPLE (one cycle per sample, idx = 0..3). All of the following is computed combinationally from the current weight registers and sample idx:
  - net = w0 + w1*in1[idx] + w2*in2[idx] (bias input is constant 1.0).
  - y = 0x3C00 if net is strictly positive (sign 0 and nonzero magnitude), else 0x0000. +0.0 and -0.0 both give y = 0.
  - e = d[idx] - y.
  - w0' = w0 + u*e; w1' = w1 + u*e*in1[idx]; w2' = w2 + u*e*in2[idx].
- On the clock edge in SAMPLE:
  - result[idx] <= y; weight registers <= w'; idx increments.
  - After idx 3, the state moves to DONE.
- DONE:
  - done = 1.
  - All outputs hold; input changes have no effect.
  - The block stays in DONE until reset.
- Timing: done rises on the 5th rising edge after reset release (1 LOAD + 4 SAMPLE). result[k] is valid from the (k+2)th edge onward.
- w*_out always reflect the weight registers, so intermediate values are visible during SAMPLE.
- FP arithmetic rules (shared multiplier and adder units):
  - Round toward zero (truncate).
  - Subnormal inputs and results flush to signed zero.
  - Exponent overflow saturates to max finite (±0x7BFF).
  - Exact cancellation yields +0.0.
  - NaN/Inf inputs are out of scope; output for them is unspecified but must not hang the FSM.
- Entries of result not yet written read 0x0000.

Test Plan:
- OR epoch: in1 = {0,1,0,1}, in2 = {0,0,1,1} (0x0000/0x3C00), d = {0,1,1,1}, u = 0x3800, w0 = w1 = w2 = 0x3C00 → result = 0x3C00 x4; w0_out = 0x3800, w1_out = 0x3C00, w2_out = 0x3C00; done high on the 5th edge after reset release.
- AND epoch: same inputs and weights, d = {0,0,0,1} → result = 0x3C00 x4; w0_out = 0xB800, w1_out = 0x3800, w2_out = 0x3800.
- Zero-net boundary: weights all 0x0000, d = {0,1,1,1}, u = 0x3800 → result = {0x0000, 0x0000, 0x3C00, 0x3C00}; w0_out = 0x3800, w1_out = 0x3800, w2_out = 0x0000.
- Reset mid-epoch: during the OR run, assert reset after the 2nd SAMPLE edge → all outputs 0x0000 and done = 0 immediately (asynchronous); after release the OR results repeat exactly.
- DONE hold: after done, run 10 extra clocks and change in1/in2/d/u/w* → result, w*_out and done unchanged.
- Negative zero: w0 = 0x8000, w1 = w2 = 0x0000, d = {0,0,0,0} → result = 0x0000 x4; weights unchanged; done = 1.
